timer_sched: RTL and testbench

TIMER_SCHED -- requirements
Module: timer_sched

---
 rtl/timer_sched.sv | 166 ++++++++++++++++
 tb/tb_timer_sched.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_sched.sv
// Shares one timer among four requesters: round-robin grant, program stop + period,
// then wait for a fresh expiry edge and pulse done to the owner.
module timer_sched #(
  parameter logic [4:0] CTRL_ADDR   = 5'b10110,
  parameter logic [4:0] PERIOD_ADDR = 5'b10111
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [127:0] req_period,
  input  logic         tmr_flag,
  output logic [3:0]   gnt,
  output logic [3:0]   done,
  output logic         busy,
  output logic         tmr_we,
  output logic [4:0]   tmr_addr,
  output logic [31:0]  tmr_data
);

  typedef enum logic [2:0] {IDLE, WR_CTRL, WR_PER, WAIT, DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_ptr, w_ptr_nxt;
  logic [1:0]  r_winner, w_winner_nxt;
  logic [31:0] r_period, w_period_nxt;
  logic        r_flag_q;
  logic [3:0]  r_gnt, w_gnt_nxt;
  logic [3:0]  r_done, w_done_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_we, w_we_nxt;
  logic [4:0]  r_addr, w_addr_nxt;
  logic [31:0] r_data, w_data_nxt;

  logic        w_found;
  logic [1:0]  w_rr_winner;
  logic [1:0]  w_idx;
  logic [31:0] w_rr_period;
  logic        w_expiry;
  logic        w_win_req;

  always_comb begin
    w_found     = 1'b0;
    w_rr_winner = r_ptr;
    w_idx       = r_ptr;
    for (int k = 0; k < 4; k++) begin
      w_idx = r_ptr + 2'(k);
      if (!w_found && req[w_idx]) begin
        w_found     = 1'b1;
        w_rr_winner = w_idx;
      end
    end
  end

  assign w_rr_period = req_period[{w_rr_winner, 5'd0} +: 32];
  // Only a 0->1 transition seen while waiting counts; a flag left high is stale.
  assign w_expiry    = tmr_flag & ~r_flag_q;
  assign w_win_req   = req[r_winner];

  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_winner_nxt = r_winner;
    w_period_nxt = r_period;
    w_gnt_nxt    = r_gnt;
    w_done_nxt   = 4'b0000;
    w_busy_nxt   = r_busy;
    w_we_nxt     = 1'b0;
    w_addr_nxt   = 5'd0;
    w_data_nxt   = 32'd0;

    case (r_state)
      IDLE: begin
        w_gnt_nxt  = 4'b0000;
        w_busy_nxt = 1'b0;
        if (w_found) begin
          w_winner_nxt = w_rr_winner;
          w_period_nxt = w_rr_period;
          w_ptr_nxt    = w_rr_winner + 2'd1;
          w_gnt_nxt    = 4'b0001 << w_rr_winner;
          w_busy_nxt   = 1'b1;
          w_state_nxt  = (w_rr_period == 32'd0) ? DONE : WR_CTRL;
        end
      end
      WR_CTRL: begin
        if (!w_win_req) begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = 4'b0000;
          w_busy_nxt  = 1'b0;
        end else begin
          w_we_nxt    = 1'b1;
          w_addr_nxt  = CTRL_ADDR;
          w_state_nxt = WR_PER;
        end
      end
      WR_PER: begin
        if (!w_win_req) begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = 4'b0000;
          w_busy_nxt  = 1'b0;
        end else begin
          w_we_nxt    = 1'b1;
          w_addr_nxt  = PERIOD_ADDR;
          w_data_nxt  = r_period;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        // Withdrawal takes priority over a simultaneous expiry.
        if (!w_win_req) begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = 4'b0000;
          w_busy_nxt  = 1'b0;
        end else if (w_expiry) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_done_nxt  = 4'b0001 << r_winner;
        w_gnt_nxt   = 4'b0000;
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = 4'b0000;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_ptr    <= 2'd0;
      r_winner <= 2'd0;
      r_period <= 32'd0;
      r_flag_q <= 1'b0;
      r_gnt    <= 4'b0000;
      r_done   <= 4'b0000;
      r_busy   <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= 5'd0;
      r_data   <= 32'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_winner <= w_winner_nxt;
      r_period <= w_period_nxt;
      r_flag_q <= tmr_flag;
      r_gnt    <= w_gnt_nxt;
      r_done   <= w_done_nxt;
      r_busy   <= w_busy_nxt;
      r_we     <= w_we_nxt;
      r_addr   <= w_addr_nxt;
      r_data   <= w_data_nxt;
    end
  end

  assign gnt      = r_gnt;
  assign done     = r_done;
  assign busy     = r_busy;
  assign tmr_we   = r_we;
  assign tmr_addr = r_addr;
  assign tmr_data = r_data;

endmodule

// File: tb/tb_timer_sched.sv
// Self-checking bench for timer_sched: directed vector table, a round-robin contention
// sequence, and randomized traffic checked against a transaction-level reference model.
module tb_timer_sched;

  localparam logic [4:0] CA = 5'b10110;
  localparam logic [4:0] PA = 5'b10111;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [127:0] req_period;
  logic         tmr_flag;
  logic [3:0]   gnt;
  logic [3:0]   done;
  logic         busy;
  logic         tmr_we;
  logic [4:0]   tmr_addr;
  logic [31:0]  tmr_data;

  timer_sched dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_period (req_period),
    .tmr_flag   (tmr_flag),
    .gnt        (gnt),
    .done       (done),
    .busy       (busy),
    .tmr_we     (tmr_we),
    .tmr_addr   (tmr_addr),
    .tmr_data   (tmr_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic [3:0]   req;
    logic [127:0] per;
    logic         flag;
    logic [3:0]   gnt;
    logic [3:0]   done;
    logic         busy;
    logic         we;
    logic [4:0]   addr;
    logic [31:0]  data;
  } vec_t;

  vec_t vecs[$];
  int   nChecks = 0;
  int   nFail   = 0;

  // Reference model state: who owns the timer and how far its transaction has progressed.
  int          mOwner = -1;
  int          mEdges = 0;
  bit          mFinish = 1'b0;
  int          mPtr = 0;
  bit          mPrevFlag = 1'b0;
  logic [31:0] mPeriod = 32'd0;
  logic [3:0]  eGnt = 4'b0;
  logic [3:0]  eDone = 4'b0;
  logic        eBusy = 1'b0;
  logic        eWe = 1'b0;
  logic [4:0]  eAddr = 5'd0;
  logic [31:0] eData = 32'd0;

  function automatic logic [127:0] mkPer(input logic [31:0] p3, input logic [31:0] p2,
                                         input logic [31:0] p1, input logic [31:0] p0);
    return {p3, p2, p1, p0};
  endfunction

  task automatic addRow(input logic r, input logic [3:0] rq, input logic [127:0] p, input logic f,
                        input logic [3:0] g, input logic [3:0] d, input logic b, input logic w,
                        input logic [4:0] a, input logic [31:0] dat);
    vec_t v;
    v.rst = r; v.req = rq; v.per = p; v.flag = f;
    v.gnt = g; v.done = d; v.busy = b; v.we = w; v.addr = a; v.data = dat;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic [127:0] p, input logic f);
    rst        = r;
    req        = rq;
    req_period = p;
    tmr_flag   = f;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] g, input logic [3:0] d,
                             input logic b, input logic w, input logic [4:0] a, input logic [31:0] dat);
    nChecks++;
    if ({gnt, done, busy, tmr_we, tmr_addr, tmr_data} !== {g, d, b, w, a, dat}) begin
      nFail++;
      $display("[TB] FAIL %s: got gnt=%b done=%b busy=%b we=%b addr=%h data=%0d, expected gnt=%b done=%b busy=%b we=%b addr=%h data=%0d",
               name, gnt, done, busy, tmr_we, tmr_addr, tmr_data, g, d, b, w, a, dat);
    end
  endtask

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] expv);
    nChecks++;
    if (act !== expv) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Predicts the outputs visible after the coming edge from the inputs applied to it.
  task automatic modelEdge(input logic r, input logic [3:0] rq, input logic [127:0] p, input logic f);
    bit rise;
    if (!r) begin
      mOwner = -1; mEdges = 0; mFinish = 1'b0; mPtr = 0; mPrevFlag = 1'b0; mPeriod = 32'd0;
      eGnt = 4'b0; eDone = 4'b0; eBusy = 1'b0; eWe = 1'b0; eAddr = 5'd0; eData = 32'd0;
      return;
    end
    rise  = f && !mPrevFlag;
    eDone = 4'b0; eWe = 1'b0; eAddr = 5'd0; eData = 32'd0;
    if (mFinish) begin
      eDone   = 4'b0001 << mOwner;
      eGnt    = 4'b0;
      eBusy   = 1'b0;
      mOwner  = -1;
      mFinish = 1'b0;
    end else if (mOwner < 0) begin
      eGnt  = 4'b0;
      eBusy = 1'b0;
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (mPtr + k) % 4;
        if (mOwner < 0 && rq[c]) mOwner = c;
      end
      if (mOwner >= 0) begin
        mPeriod = p[32*mOwner +: 32];
        mPtr    = (mOwner + 1) % 4;
        mEdges  = 0;
        eGnt    = 4'b0001 << mOwner;
        eBusy   = 1'b1;
        mFinish = (mPeriod == 32'd0);
      end
    end else if (!rq[mOwner]) begin
      mOwner = -1;
      eGnt   = 4'b0;
      eBusy  = 1'b0;
    end else begin
      mEdges++;
      if (mEdges == 1) begin
        eWe = 1'b1; eAddr = CA;
      end else if (mEdges == 2) begin
        eWe = 1'b1; eAddr = PA; eData = mPeriod;
      end else if (rise) begin
        mFinish = 1'b1;
      end
    end
    mPrevFlag = f;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [127:0] pA, pC, pD, pE, per, junk, rp;
    logic [3:0]   rq;
    logic         rr, rf;
    int           who, waitCnt;

    rst = 1'b0; req = 4'b0; req_period = '0; tmr_flag = 1'b0;
    pA = mkPer(0, 0, 0, 200);
    pC = mkPer(0, 0, 0, 5);
    pD = mkPer(0, 0, 9, 7);
    pE = mkPer(4, 6, 3, 0);

    // Single request, period 200.
    addRow(0, 4'b0000, pA, 0, 4'b0000, 4'b0000, 0, 0, 5'd0, 32'd0);
    addRow(1, 4'b0001, pA, 0, 4'b0001, 4'b0000, 1, 0, 5'd0, 32'd0);
    addRow(1, 4'b0001, pA, 0, 4'b0001, 4'b0000, 1, 1, CA,   32'd0);
    addRow(1, 4'b0001, pA, 0, 4'b0001, 4'b0000, 1, 1, PA,   32'd200);
    addRow(1, 4'b0001, pA, 0, 4'b0001, 4'b0000, 1, 0, 5'd0, 32'd0);
    addRow(1, 4'b0001, pA, 1, 4'b0001, 4'b0000, 1, 0, 5'd0, 32'd0);
    addRow(1, 4'b0001, pA, 1, 4'b0000, 4'b0001, 0, 0, 5'd0, 32'd0);
    addRow(1, 4'b0000, pA, 0, 4'b0000, 4'b0000, 0, 0, 5'd0, 32'd0);
    // Zero period: grant then done, no timer writes.
    addRow(0, 4'b0000, '0, 0, 4'b0000, 4'b0000, 0, 0, 5'd0, 32'd0);
    addRow(1, 4'b0100, '0, 0, 4'b0100, 4'b0000, 1, 0, 5'd0, 32'd0);
    addRow(1, 4'b0100, '0, 0, 4'b0000, 4'b0100, 0, 0, 5'd0, 32'd0);
    addRow(1, 4'b0000, '0, 0, 4'b0000, 4'b0000, 0, 0, 5'd0, 32'd0);
    // Stale flag held high into WAIT, then a genuine rise.
    addRow(0, 4'b0000, pC, 0, 4'b0000, 4'b0000, 0, 0, 5'd0, 32'd0);
    addRow(1, 4'b0001, pC, 1, 4'b0001, 4'b0000, 1, 0, 5'd0, 32'd0);
    addRow(1, 4'b0001, pC, 1, 4'b0001, 4'b0000, 1, 1, CA,   32'd0);
    addRow(1, 4'b0001, pC, 1, 4'b0001, 4'b0000, 1, 1, PA,   32'd5);
    addRow(1, 4'b0001, pC, 1, 4'b0001, 4'b0000, 1, 0, 5'd0, 32'd0);
    addRow(1, 4'b0001, pC, 1, 4'b0001, 4'b0000, 1, 0, 5'd0, 32'd0);
    addRow(1, 4'b0001, pC, 0, 4'b0001, 4'b0000, 1, 0, 5'd0, 32'd0);
    addRow(1, 4'b0001, pC, 1, 4'b0001, 4'b0000, 1, 0, 5'd0, 32'd0);
    addRow(1, 4'b0001, pC, 1, 4'b0000, 4'b0001, 0, 0, 5'd0, 32'd0);
    addRow(1, 4'b0000, pC, 0, 4'b0000, 4'b0000, 0, 0, 5'd0, 32'd0);
    // Withdrawal in WAIT racing an expiry, requester 1 served next, then withdrawn in WR_PER.
    addRow(0, 4'b0000, pD, 0, 4'b0000, 4'b0000, 0, 0, 5'd0, 32'd0);
    addRow(1, 4'b0011, pD, 0, 4'b0001, 4'b0000, 1, 0, 5'd0, 32'd0);
    addRow(1, 4'b0011, pD, 0, 4'b0001, 4'b0000, 1, 1, CA,   32'd0);
    addRow(1, 4'b0011, pD, 0, 4'b0001, 4'b0000, 1, 1, PA,   32'd7);
    addRow(1, 4'b0011, pD, 0, 4'b0001, 4'b0000, 1, 0, 5'd0, 32'd0);
    addRow(1, 4'b0010, pD, 1, 4'b0000, 4'b0000, 0, 0, 5'd0, 32'd0);
    addRow(1, 4'b0010, pD, 1, 4'b0010, 4'b0000, 1, 0, 5'd0, 32'd0);
    addRow(1, 4'b0010, pD, 1, 4'b0010, 4'b0000, 1, 1, CA,   32'd0);
    addRow(1, 4'b0000, pD, 1, 4'b0000, 4'b0000, 0, 0, 5'd0, 32'd0);
    addRow(1, 4'b0000, pD, 0, 4'b0000, 4'b0000, 0, 0, 5'd0, 32'd0);
    // Reset mid-WAIT clears the pointer: requester 1 wins ahead of 3.
    addRow(0, 4'b0000, pE, 0, 4'b0000, 4'b0000, 0, 0, 5'd0, 32'd0);
    addRow(1, 4'b0100, pE, 0, 4'b0100, 4'b0000, 1, 0, 5'd0, 32'd0);
    addRow(1, 4'b0100, pE, 0, 4'b0100, 4'b0000, 1, 1, CA,   32'd0);
    addRow(1, 4'b0100, pE, 0, 4'b0100, 4'b0000, 1, 1, PA,   32'd6);
    addRow(1, 4'b0100, pE, 0, 4'b0100, 4'b0000, 1, 0, 5'd0, 32'd0);
    addRow(0, 4'b0100, pE, 1, 4'b0000, 4'b0000, 0, 0, 5'd0, 32'd0);
    addRow(1, 4'b1010, pE, 1, 4'b0010, 4'b0000, 1, 0, 5'd0, 32'd0);
    addRow(1, 4'b1010, pE, 1, 4'b0010, 4'b0000, 1, 1, CA,   32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].per, vecs[i].flag);
      checkOutput($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].done, vecs[i].busy,
                  vecs[i].we, vecs[i].addr, vecs[i].data);
    end

    // Contention: all four held, grants rotate 0,1,2,3,0; periods changed after grant are ignored.
    per  = mkPer(40, 30, 20, 10);
    junk = mkPer(99, 99, 99, 99);
    applyStimulus(0, 4'b0000, per, 0);
    checkOutput("rr_reset", 4'b0, 4'b0, 0, 0, 5'd0, 32'd0);
    for (int t = 0; t < 5; t++) begin
      who = t % 4;
      waitCnt = 0;
      applyStimulus(1, 4'b1111, per, 0);
      while (gnt == 4'b0 && waitCnt < 8) begin
        applyStimulus(1, 4'b1111, per, 0);
        waitCnt++;
      end
      checkValue($sformatf("rr_gnt%0d", t), {28'd0, gnt}, 32'(1 << who));
      applyStimulus(1, 4'b1111, junk, 0);
      checkOutput($sformatf("rr_ctrl%0d", t), 4'(1 << who), 4'b0, 1, 1, CA, 32'd0);
      applyStimulus(1, 4'b1111, junk, 0);
      checkOutput($sformatf("rr_per%0d", t), 4'(1 << who), 4'b0, 1, 1, PA, 32'(10 * (who + 1)));
      applyStimulus(1, 4'b1111, junk, 0);
      applyStimulus(1, 4'b1111, junk, 1);
      applyStimulus(1, 4'b1111, junk, 0);
      checkOutput($sformatf("rr_done%0d", t), 4'b0, 4'(1 << who), 0, 0, 5'd0, 32'd0);
    end

    // Randomized traffic against the reference model.
    rq = 4'b0; rp = '0; rf = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rr = (cyc == 0) ? 1'b0 : ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 5) == 0) rq = 4'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        for (int j = 0; j < 4; j++)
          rp[32*j +: 32] = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
      end
      if ($urandom_range(0, 2) == 0) rf = ~rf;
      modelEdge(rr, rq, rp, rf);
      applyStimulus(rr, rq, rp, rf);
      checkOutput($sformatf("rand%0d", cyc), eGnt, eDone, eBusy, eWe, eAddr, eData);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
